// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated 16-bit word memory answering CPU load/store requests
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_byte_en,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_error
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] LAT  = 4'(LATENCY);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  write_q;
    logic [15:0]           addr_q;
    logic [15:0]           wdata_q;
    logic [1:0]            be_q;
    logic [15:0]           mem [2**ADDR_WIDTH] = '{default: '0};
    logic                  accept;
    logic                  access;
    logic                  a_write;
    logic                  a_err;
    logic [15:0]           a_addr;
    logic [15:0]           a_wdata;
    logic [1:0]            a_be;
    logic [ADDR_WIDTH-1:0] a_idx;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign accept     = req_valid && req_ready;
    // with zero latency the access happens at the acceptance edge, so it must use the live request
    assign access  = state == IDLE ? accept && LAT == 4'd0 : state == WAIT && cnt == 4'd1;
    assign a_write = state == IDLE ? req_write : write_q;
    assign a_addr  = state == IDLE ? req_addr : addr_q;
    assign a_wdata = state == IDLE ? req_wdata : wdata_q;
    assign a_be    = state == IDLE ? req_byte_en : be_q;
    assign a_idx   = a_addr[ADDR_WIDTH:1];
    assign a_err   = a_addr[0] || (a_addr >> (ADDR_WIDTH + 1)) != 16'd0;

    // request capture, wait-state countdown, response hold and release
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_data  <= 16'd0;
            resp_error <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                cnt     <= LAT;
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_byte_en;
                state   <= LAT == 4'd0 ? RESP : WAIT;
            end
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
        end else if (state == RESP) begin
            if (resp_ready) begin
                state      <= IDLE;
                resp_data  <= 16'd0;
                resp_error <= 1'b0;
            end
        end else begin
            state <= IDLE;
        end
        if (!rst && access) begin
            resp_error <= a_err;
            resp_data  <= a_err || a_write ? 16'd0 : mem[a_idx];
        end
    end

    // byte-masked store at the access edge; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && access && a_write && !a_err) begin
            if (a_be[0]) mem[a_idx][7:0] <= a_wdata[7:0];
            if (a_be[1]) mem[a_idx][15:8] <= a_wdata[15:8];
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for the data memory responder
module tb_data_mem_responder;
    typedef struct {
        logic [15:0] d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, resp_valid, resp_ready = 1'b1, resp_error;
    logic [15:0] req_addr = '0, req_wdata = '0, resp_data;
    logic [1:0]  req_byte_en = '0;

    logic        x_req_valid = 1'b0, x_req_ready, x_req_write = 1'b0, x_resp_valid, x_resp_error;
    logic [15:0] x_req_addr = '0, x_req_wdata = '0, x_resp_data;
    logic [1:0]  x_req_byte_en = '0;

    logic        y_rst = 1'b1, y_req_valid = 1'b0, y_req_ready, y_req_write = 1'b0, y_resp_valid, y_resp_error;
    logic [15:0] y_req_addr = '0, y_req_wdata = '0, y_resp_data;
    logic [1:0]  y_req_byte_en = '0;
    logic        seen;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_error(resp_error)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst), .req_valid(x_req_valid), .req_ready(x_req_ready), .req_write(x_req_write),
        .req_addr(x_req_addr), .req_wdata(x_req_wdata), .req_byte_en(x_req_byte_en), .resp_valid(x_resp_valid),
        .resp_ready(1'b1), .resp_data(x_resp_data), .resp_error(x_resp_error)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst(y_rst), .req_valid(y_req_valid), .req_ready(y_req_ready), .req_write(y_req_write),
        .req_addr(y_req_addr), .req_wdata(y_req_wdata), .req_byte_en(y_req_byte_en), .resp_valid(y_resp_valid),
        .resp_ready(1'b1), .resp_data(y_resp_data), .resp_error(y_resp_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one request on the LATENCY=2 instance; the monitor checks its response
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                         input logic [15:0] ed, input logic ee);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_byte_en = be;
        exp_q.push_back('{ed, ee});
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = 16'hFFFF; req_wdata = ~d; req_byte_en = 2'b11;
        n = 0;
        while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", n, 2);
        if (resp_ready) begin
            @(posedge clk); #1;
            chk("cleared", {13'd0, resp_valid, resp_error, req_ready, resp_data}, {16'd1, 16'd0});
        end
    endtask

    // monitor: compare every consumed response against the scoreboard
    initial forever begin
        @(negedge clk);
        if (resp_valid && resp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got data %h err %b with nothing outstanding", resp_data, resp_error);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (resp_data !== e.d || resp_error !== e.e) begin
                    errors++;
                    $display("FAIL resp: got data %h err %b expected data %h err %b", resp_data, resp_error, e.d, e.e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555; req_byte_en = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; y_rst = 1'b0; req_valid = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp", {resp_valid, resp_error, resp_data}, 0);
        chk("rst_state_l3", {y_req_ready, y_resp_valid}, 2'b10);

        issue(1, 16'h0004, 16'hBEEF, 2'b11, 16'h0000, 0);
        issue(0, 16'h0004, 16'h0000, 2'b00, 16'hBEEF, 0);
        issue(1, 16'h0010, 16'h1234, 2'b11, 16'h0000, 0);
        issue(1, 16'h0010, 16'hAB00, 2'b10, 16'h0000, 0);
        issue(0, 16'h0010, 16'h0000, 2'b11, 16'hAB34, 0);
        issue(1, 16'h0010, 16'h00CD, 2'b01, 16'h0000, 0);
        issue(0, 16'h0010, 16'h0000, 2'b01, 16'hABCD, 0);
        issue(1, 16'h0012, 16'hFFFF, 2'b00, 16'h0000, 0);
        issue(0, 16'h0012, 16'h0000, 2'b00, 16'h0000, 0);
        issue(0, 16'h0003, 16'h0000, 2'b00, 16'h0000, 1);
        issue(1, 16'h0005, 16'hFFFF, 2'b11, 16'h0000, 1);
        issue(0, 16'h0004, 16'h0000, 2'b00, 16'hBEEF, 0);
        issue(1, 16'h0200, 16'h7777, 2'b11, 16'h0000, 1);
        issue(0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0);
        issue(0, 16'h0020, 16'h0000, 2'b00, 16'h0000, 0);
        issue(1, 16'h01FE, 16'hA5A5, 2'b11, 16'h0000, 0);
        issue(0, 16'h01FE, 16'h0000, 2'b00, 16'hA5A5, 0);
        issue(0, 16'h01FF, 16'h0000, 2'b00, 16'h0000, 1);

        resp_ready = 1'b0;
        issue(0, 16'h0004, 16'h0000, 2'b00, 16'hBEEF, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", {resp_valid, req_ready, resp_error, resp_data}, {3'b100, 16'hBEEF});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {req_ready, resp_valid}, 2'b10);

        x_req_valid = 1'b1; x_req_write = 1'b1; x_req_addr = 16'h0002; x_req_wdata = 16'h4242; x_req_byte_en = 2'b11;
        @(posedge clk); #1;
        x_req_valid = 1'b0; x_req_wdata = 16'h0000;
        chk("l0_store", {x_resp_valid, x_req_ready, x_resp_error, x_resp_data}, {3'b100, 16'h0000});
        @(posedge clk); #1;
        chk("l0_idle", {x_req_ready, x_resp_valid}, 2'b10);
        x_req_valid = 1'b1; x_req_write = 1'b0;
        @(posedge clk); #1;
        x_req_valid = 1'b0;
        chk("l0_load", {x_resp_valid, x_resp_error, x_resp_data}, {2'b10, 16'h4242});
        @(posedge clk); #1;

        y_req_valid = 1'b1; y_req_write = 1'b1; y_req_addr = 16'h0008; y_req_wdata = 16'h1111; y_req_byte_en = 2'b11;
        @(posedge clk); #1;
        y_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("l3_not_yet", y_resp_valid, 0);
        @(posedge clk); #1;
        chk("l3_store_resp", {y_resp_valid, y_resp_error}, 2'b10);
        @(posedge clk); #1;
        y_req_valid = 1'b1; y_req_wdata = 16'h9999;
        @(posedge clk); #1;
        y_req_valid = 1'b0;
        @(posedge clk); #1;
        y_rst = 1'b1;
        @(posedge clk); #1;
        y_rst = 1'b0;
        chk("l3_rst_idle", {y_req_ready, y_resp_valid}, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | y_resp_valid;
        end
        chk("l3_no_resp", seen, 0);
        y_req_valid = 1'b1; y_req_write = 1'b0;
        @(posedge clk); #1;
        y_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("l3_unchanged", {y_resp_valid, y_resp_error, y_resp_data}, {2'b10, 16'h1111});

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
